// File: rtl/mips_pkg.sv
// Shared MIPS encodings and datapath constants used by the fetch stage and the
// main decoder.
package mips_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Pseudo-direct jump: top nibble of the current PC, word index from the IR.
  function automatic logic [WIDTH-1:0] jump_target(input logic [WIDTH-1:0] pc,
                                                   input logic [WIDTH-1:0] instr);
    return {pc[WIDTH-1 -: 4], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low reset to a configurable value.
module flopenr #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pc_ir_unit.sv
// Fetch-side datapath of the multicycle MIPS: PC, IR, MDR and ALUOut registers,
// unified memory address mux, decoder field slices and an IR-load counter.
module pc_ir_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IorD,
  input  logic             IRwrite,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic [1:0]       pcsrc,
  input  logic             zero,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] memrdata,
  output logic [WIDTH-1:0] memaddr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] signimm,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] aluout,
  output logic [CNT_W-1:0] fetch_cnt
);

  import mips_pkg::*;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] mdr_q;
  logic [WIDTH-1:0] aluout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pcen;
  pcsrc_t           pcsel;

  assign pcsel = pcsrc_t'(pcsrc);
  assign pcen  = pcwrite | (branch & zero);

  // The reserved select feeds the PC back so an enabled write is a no-op.
  always_comb begin
    pc_d = pc_q;
    unique case (pcsel)
      PCSRC_ALU:    pc_d = aluresult;
      PCSRC_ALUOUT: pc_d = aluout_q;
      PCSRC_JUMP:   pc_d = jump_target(pc_q, ir_q);
      PCSRC_RSVD:   pc_d = pc_q;
    endcase
  end

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  flopenr #(
    .W       (WIDTH),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (pcen),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  flopenr #(
    .W       (WIDTH),
    .RST_VAL ('0)
  ) u_ir_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (IRwrite),
    .d_i    (memrdata),
    .q_o    (ir_q)
  );

  flopenr #(
    .W       (CNT_W),
    .RST_VAL ('0)
  ) u_fetch_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (IRwrite),
    .d_i    (cnt_d),
    .q_o    (cnt_q)
  );

  // MDR and ALUOut capture every cycle; their contents are only meaningful one
  // cycle after the address/operands that produced them.
  flopenr #(
    .W       (WIDTH),
    .RST_VAL ('0)
  ) u_mdr_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .d_i    (memrdata),
    .q_o    (mdr_q)
  );

  flopenr #(
    .W       (WIDTH),
    .RST_VAL ('0)
  ) u_aluout_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .d_i    (aluresult),
    .q_o    (aluout_q)
  );

  assign memaddr   = IorD ? aluout_q : pc_q;
  assign pc        = pc_q;
  assign instr     = ir_q;
  assign data      = mdr_q;
  assign aluout    = aluout_q;
  assign fetch_cnt = cnt_q;

  assign op      = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign signimm = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: a driver pushes expected outputs from a
// behavioural model, a monitor pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IorD, IRwrite, pcwrite, branch, zero;
  logic [1:0]  pcsrc;
  logic [31:0] aluresult, memrdata;
  logic [31:0] memaddr, pc, instr, signimm, data, aluout;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] fetch_cnt;

  always #5 clk = ~clk;

  pc_ir_unit dut (
    .clk       (clk),
    .reset     (rst_n),
    .IorD      (IorD),
    .IRwrite   (IRwrite),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .pcsrc     (pcsrc),
    .zero      (zero),
    .aluresult (aluresult),
    .memrdata  (memrdata),
    .memaddr   (memaddr),
    .pc        (pc),
    .instr     (instr),
    .op        (op),
    .funct     (funct),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .signimm   (signimm),
    .data      (data),
    .aluout    (aluout),
    .fetch_cnt (fetch_cnt)
  );

  typedef struct packed {
    logic [31:0] memaddr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [31:0] aluout;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Architectural state of the reference model
  logic [31:0] m_pc, m_ir, m_mdr, m_alu;
  int unsigned m_cnt;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_alu = 32'h0; m_cnt = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.memaddr = IorD ? m_alu : m_pc;
    e.pc      = m_pc;
    e.instr   = m_ir;
    e.data    = m_mdr;
    e.aluout  = m_alu;
    e.cnt     = 16'(m_cnt % 65536);
    q.push_back(e);
  endtask

  task automatic step(input bit iord, input bit irw, input bit pcw, input bit br,
                      input bit z, input logic [1:0] ps,
                      input logic [31:0] alur, input logic [31:0] memr);
    logic [31:0] nxt;
    #1;
    IorD = iord; IRwrite = irw; pcwrite = pcw; branch = br; zero = z;
    pcsrc = ps; aluresult = alur; memrdata = memr;
    push_exp();
    @(posedge clk);
    if (rst_n) begin
      case (ps)
        2'd0:    nxt = alur;
        2'd1:    nxt = m_alu;
        2'd2:    nxt = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
        default: nxt = m_pc;
      endcase
      if (pcw || (br && z)) m_pc = nxt;
      if (irw) begin
        m_ir  = memr;
        m_cnt = m_cnt + 1;
      end
      m_mdr = memr;
      m_alu = alur;
    end
  endtask

  task automatic rand_step(input bit irw);
    step(1'($urandom_range(0, 1)), irw, 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         2'($urandom_range(0, 3)), $urandom, $urandom);
  endtask

  // Reset is dropped between edges and checked before any further edge.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    #1;
    cmp("async_rst_pc", pc, 32'h0);
    cmp("async_rst_instr", instr, 32'h0);
    cmp("async_rst_cnt", {16'h0, fetch_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("memaddr", memaddr, e.memaddr);
        cmp("pc", pc, e.pc);
        cmp("instr", instr, e.instr);
        cmp("data", data, e.data);
        cmp("aluout", aluout, e.aluout);
        cmp("fetch_cnt", {16'h0, fetch_cnt}, {16'h0, e.cnt});
        cmp("op", {26'h0, op}, e.instr >> 26);
        cmp("rs", {27'h0, rs}, (e.instr >> 21) & 32'h1F);
        cmp("rt", {27'h0, rt}, (e.instr >> 16) & 32'h1F);
        cmp("rd", {27'h0, rd}, (e.instr >> 11) & 32'h1F);
        cmp("funct", {26'h0, funct}, e.instr & 32'h3F);
        cmp("signimm", signimm, 32'(int'($signed(e.instr[15:0]))));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    IorD = 0; IRwrite = 0; pcwrite = 0; branch = 0; zero = 0;
    pcsrc = 2'b00; aluresult = 32'h0; memrdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_pc", pc, 32'h0);
    cmp("reset_instr", instr, 32'h0);
    cmp("reset_data", data, 32'h0);
    cmp("reset_aluout", aluout, 32'h0);
    cmp("reset_cnt", {16'h0, fetch_cnt}, 32'h0);
    rst_n = 1'b1;

    // Fetch
    step(0, 1, 1, 0, 0, 2'b00, 32'h4, 32'h8C08_0004);
    #1;
    cmp("fetch_instr", instr, 32'h8C08_0004);
    cmp("fetch_op", {26'h0, op}, 32'h23);
    cmp("fetch_rt", {27'h0, rt}, 32'h8);
    cmp("fetch_signimm", signimm, 32'h4);
    cmp("fetch_pc", pc, 32'h4);
    cmp("fetch_cnt1", {16'h0, fetch_cnt}, 32'h1);

    // Branch not taken, then taken
    step(0, 0, 0, 0, 0, 2'b00, 32'h100, 32'h0);
    step(0, 0, 0, 1, 0, 2'b01, 32'h100, 32'h0);
    #1;
    cmp("branch_nt_pc", pc, 32'h4);
    step(0, 0, 0, 1, 1, 2'b01, 32'h100, 32'h0);
    #1;
    cmp("branch_t_pc", pc, 32'h100);

    // Jump
    step(0, 1, 1, 0, 0, 2'b00, 32'h3000_0010, 32'h0800_0040);
    step(0, 0, 1, 0, 0, 2'b10, 32'h0, 32'h0);
    #1;
    cmp("jump_pc", pc, 32'h3000_0100);

    // Load path
    step(0, 0, 0, 0, 0, 2'b00, 32'h200, 32'h0);
    #1;
    IorD = 1'b1;
    #1;
    cmp("load_memaddr", memaddr, 32'h200);
    step(1, 0, 0, 0, 0, 2'b00, 32'h0, 32'h1234);
    #1;
    cmp("load_data", data, 32'h1234);
    cmp("load_instr_hold", instr, 32'h0800_0040);

    // Reserved select holds PC even when enabled
    step(0, 0, 1, 1, 1, 2'b11, 32'hFFFF_FFF0, 32'h0);
    #1;
    cmp("rsvd_pc", pc, 32'h3000_0100);

    // Mid-instruction reset
    step(0, 1, 1, 0, 0, 2'b00, 32'h40, 32'hDEAD_BEEF);
    #1;
    cmp("pre_rst_instr", instr, 32'hDEAD_BEEF);
    async_reset();

    for (int i = 0; i < 400; i++) rand_step(1'($urandom_range(0, 1)));

    // Counter wrap
    async_reset();
    for (int i = 0; i < 65535; i++) rand_step(1'b1);
    #1;
    cmp("cnt_max", {16'h0, fetch_cnt}, 32'hFFFF);
    rand_step(1'b1);
    #1;
    cmp("cnt_wrap", {16'h0, fetch_cnt}, 32'h0);

    for (int i = 0; i < 100; i++) rand_step(1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
